// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data single-port memory arbiter.
package mem_arb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores, one transaction
// at a time, with round-robin on contention and flush-killed fetch responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_valid,
    output logic              d_stall,

    input  logic              flush,

    output logic              m_req,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_be,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [XLEN-1:0]   m_rdata
);

    localparam int BW = XLEN / 8;

    state_e            state_q, state_d;
    owner_e            own_q, own_d;
    owner_e            last_q, last_d;
    logic              drop_q, drop_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [BW-1:0]     m_be_q, m_be_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;

    logic              fetch_ok;
    logic              pick_d;
    logic              pick_i;

    // A flush in the grant cycle makes the fetch ineligible; D wins unless I is due.
    assign fetch_ok = if_req & ~flush;
    assign pick_d   = d_req & (~fetch_ok | (last_q == OWN_I));
    assign pick_i   = fetch_ok & ~pick_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            own_q      <= OWN_I;
            last_q     <= OWN_I;
            drop_q     <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            last_q     <= last_d;
            drop_q     <= drop_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        last_d     = last_q;
        drop_d     = drop_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (pick_d) begin
                    own_d     = OWN_D;
                    last_d    = OWN_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                    state_d   = ISSUE;
                end else if (pick_i) begin
                    own_d     = OWN_I;
                    last_d    = OWN_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_be_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (flush && own_q == OWN_I) begin
                    drop_d = 1'b1;
                end
                if (m_ready) begin
                    m_req_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush && own_q == OWN_I) begin
                    drop_d = 1'b1;
                end
                if (m_rvalid) begin
                    if (own_q == OWN_I) begin
                        if_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = m_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A flush landing on the response cycle itself still kills the fetch pulse.
    assign if_valid = (state_q == RESP) && (own_q == OWN_I) && !drop_q && !flush;
    assign d_valid  = (state_q == RESP) && (own_q == OWN_D);
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, store, flush and reset cases.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [XLEN-1:0]   if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic [XLEN-1:0]   d_rdata;
    logic              d_valid;
    logic              d_stall;
    logic              flush;
    logic              m_req;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [XLEN/8-1:0] m_be;
    logic              m_ready;
    logic              m_rvalid;
    logic [XLEN-1:0]   m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_stall  (d_stall),
        .flush    (flush),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; flush = 1'b0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        cyc(); cyc();
        reset_n = 1'b1;
        #1;
        chk("rst_m_req",    m_req,    0);
        chk("rst_m_addr",   m_addr,   0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid",  d_valid,  0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata",  d_rdata,  0);

        // Fetch-only, minimum latency
        if_req = 1'b1; if_addr = 32'h100; m_ready = 1'b1;
        #1;
        chk("f_c0_stall", if_stall, 1);
        chk("f_c0_mreq",  m_req,    0);
        cyc(); #1;
        chk("f_c1_mreq",  m_req,    1);
        chk("f_c1_maddr", m_addr,   32'h100);
        chk("f_c1_mwe",   m_we,     0);
        chk("f_c1_stall", if_stall, 1);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h00500093; #1;
        chk("f_c2_stall", if_stall, 1);
        chk("f_c2_valid", if_valid, 0);
        cyc(); m_rvalid = 1'b0; #1;
        chk("f_c3_valid", if_valid, 1);
        chk("f_c3_rdata", if_rdata, 32'h00500093);
        chk("f_c3_stall", if_stall, 0);
        if_req = 1'b0;
        cyc(); #1;
        chk("f_c4_valid", if_valid, 0);
        chk("f_c4_mreq",  m_req,    0);

        // Contention after reset: D first, then I, then D again
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; m_ready = 1'b1;
        cyc(); #1;
        chk("c_g1_maddr", m_addr, 32'h2000);
        chk("c_g1_mwe",   m_we,   0);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h11112222;
        cyc(); m_rvalid = 1'b0; #1;
        chk("c_r1_dvalid",  d_valid,  1);
        chk("c_r1_drdata",  d_rdata,  32'h11112222);
        chk("c_r1_ifvalid", if_valid, 0);
        chk("c_r1_ifstall", if_stall, 1);
        chk("c_r1_dstall",  d_stall,  0);
        cyc(); #1;
        chk("c_idle_dstall", d_stall, 1);
        cyc(); #1;
        chk("c_g2_maddr", m_addr, 32'h200);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h33334444;
        cyc(); m_rvalid = 1'b0; #1;
        chk("c_r2_ifvalid", if_valid, 1);
        chk("c_r2_ifrdata", if_rdata, 32'h33334444);
        chk("c_r2_dvalid",  d_valid,  0);
        cyc(); cyc(); #1;
        chk("c_g3_maddr", m_addr, 32'h2000);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h55556666;
        cyc(); m_rvalid = 1'b0; #1;
        chk("c_r3_dvalid", d_valid, 1);
        chk("c_r3_drdata", d_rdata, 32'h55556666);
        d_req = 1'b0; if_req = 1'b0;
        cyc();

        // Store with m_ready held low for 3 ISSUE cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) m_ready = 1'b1;
            #1;
            chk($sformatf("s_iss%0d_mreq", i),   m_req,   1);
            chk($sformatf("s_iss%0d_mwe", i),    m_we,    1);
            chk($sformatf("s_iss%0d_maddr", i),  m_addr,  32'h3000);
            chk($sformatf("s_iss%0d_mwdata", i), m_wdata, 32'hDEADBEEF);
            chk($sformatf("s_iss%0d_mbe", i),    m_be,    4'b0011);
            chk($sformatf("s_iss%0d_dvalid", i), d_valid, 0);
        end
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h0; #1;
        chk("s_wait_mreq",   m_req,   0);
        chk("s_wait_dvalid", d_valid, 0);
        cyc(); m_rvalid = 1'b0; #1;
        chk("s_resp_dvalid", d_valid, 1);
        d_req = 1'b0; d_we = 1'b0; d_be = '0;
        cyc(); #1;
        chk("s_after_dvalid", d_valid, 0);

        // Flush during WAIT of a fetch, then a normal fetch
        if_req = 1'b1; if_addr = 32'h400; m_ready = 1'b1;
        cyc();
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
        cyc(); m_rvalid = 1'b0; #1;
        chk("k_resp_ifvalid", if_valid, 0);
        chk("k_resp_ifstall", if_stall, 1);
        if_addr = 32'h404;
        cyc(); #1;
        chk("k_idle_mreq", m_req, 0);
        cyc(); #1;
        chk("k_g2_maddr", m_addr, 32'h404);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h0000AAAA;
        cyc(); m_rvalid = 1'b0; #1;
        chk("k_r2_ifvalid", if_valid, 1);
        chk("k_r2_ifrdata", if_rdata, 32'h0000AAAA);
        if_addr = 32'h408;
        cyc();
        cyc(); #1;
        chk("k_g3_maddr", m_addr, 32'h408);
        cyc(); flush = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD1BAD1;
        cyc(); flush = 1'b0; m_rvalid = 1'b0; #1;
        chk("k_r3_ifvalid", if_valid, 0);
        if_req = 1'b0;
        cyc();

        // Flush while D owns the port
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; m_ready = 1'b1;
        cyc(); flush = 1'b1;
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h5555AAAA;
        cyc(); m_rvalid = 1'b0; #1;
        chk("fd_resp_dvalid", d_valid, 1);
        chk("fd_resp_drdata", d_rdata, 32'h5555AAAA);
        flush = 1'b0; d_req = 1'b0;
        cyc();

        // Reset in the middle of WAIT, then a stray response
        if_req = 1'b1; if_addr = 32'h600; m_ready = 1'b1;
        cyc();
        cyc(); reset_n = 1'b0;
        cyc(); reset_n = 1'b1; if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h66666666; #1;
        chk("r_mreq",     m_req,    0);
        chk("r_maddr",    m_addr,   0);
        chk("r_ifvalid",  if_valid, 0);
        chk("r_ifrdata",  if_rdata, 0);
        chk("r_drdata",   d_rdata,  0);
        cyc(); m_rvalid = 1'b0; #1;
        chk("r2_ifvalid", if_valid, 0);
        chk("r2_dvalid",  d_valid,  0);
        chk("r2_ifrdata", if_rdata, 0);
        chk("r2_mreq",    m_req,    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
